apb3_bridge_ctrl: RTL



---
 rtl/apb3_bridge_ctrl_if.sv | 32 +++
 rtl/apb3_bridge_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/apb3_bridge_ctrl_if.sv
// AHB-Lite / APB3 control-side signals of the bridge sequencer.
// Also carries the load strobes for the bridge's address/data registers.
interface apb3_bridge_ctrl_if;
  logic       HSEL;
  logic [1:0] HTRANS;
  logic       HWRITE;
  logic       HREADY;
  logic       HREADYOUT;
  logic       HRESP;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic       PREADY;
  logic       PSLVERR;
  logic       addr_ld;
  logic       wdata_ld;
  logic       rdata_ld;

  // Sequencer side: AHB slave, APB master, datapath strobe source.
  modport slave (
    input  HSEL, HTRANS, HWRITE, HREADY, PREADY, PSLVERR,
    output HREADYOUT, HRESP, PSEL, PENABLE, PWRITE,
           addr_ld, wdata_ld, rdata_ld
  );

  // Environment side: drives AHB and APB inputs, observes the outputs.
  modport master (
    output HSEL, HTRANS, HWRITE, HREADY, PREADY, PSLVERR,
    input  HREADYOUT, HRESP, PSEL, PENABLE, PWRITE,
           addr_ld, wdata_ld, rdata_ld
  );
endinterface

// File: rtl/apb3_bridge_ctrl.sv
// AHB-Lite to APB3 bridge control sequencer.
// Runs the APB SETUP/ACCESS phases and stalls the AHB data phase.
// Answers OKAY or a two-cycle ERROR, and strobes the PADDR/PWDATA/HRDATA registers.
module apb3_bridge_ctrl #(
  parameter bit ERR_EN = 1'b1
) (
  input  logic               HCLK,
  input  logic               HRESETN,
  apb3_bridge_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
  } state_e;

  state_e state_q, state_d;
  logic   pwrite_q, pwrite_d;
  logic   accept;
  logic   hreadyout, hresp, psel, penable, wdata_ld, rdata_ld;

  // A new transfer is taken only when the previous data phase is ending (or idle).
  always_comb begin
    accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY &
             ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR2));
  end

  // State and registered APB direction; reset drops PSEL/PENABLE immediately.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q  <= S_IDLE;
      pwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
    end
  end

  // Next-state: writes spend one cycle in WDATA so HWDATA can be captured before SETUP.
  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    if (accept) pwrite_d = bus.HWRITE;
    case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept) state_d = bus.HWRITE ? S_WDATA : S_SETUP;
        else        state_d = S_IDLE;
      end
      S_WDATA:  state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (bus.PREADY) state_d = (bus.PSLVERR && ERR_EN) ? S_ERR1 : S_DONE;
      end
      S_ERR1:   state_d = S_ERR2;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; read data is captured even on an erroring read.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    wdata_ld  = 1'b0;
    rdata_ld  = 1'b0;
    case (state_q)
      S_WDATA: begin
        hreadyout = 1'b0;
        wdata_ld  = 1'b1;
      end
      S_SETUP: begin
        hreadyout = 1'b0;
        psel      = 1'b1;
      end
      S_ACCESS: begin
        hreadyout = 1'b0;
        psel      = 1'b1;
        penable   = 1'b1;
        rdata_ld  = bus.PREADY & ~pwrite_q;
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      S_ERR2:  hresp = 1'b1;
      default: ;
    endcase
  end

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.PSEL      = psel;
  assign bus.PENABLE   = penable;
  assign bus.PWRITE    = pwrite_q;
  assign bus.addr_ld   = accept;
  assign bus.wdata_ld  = wdata_ld;
  assign bus.rdata_ld  = rdata_ld;

endmodule
